rll_key_loader: RTL
===================

Name: rll_key_loader

Overview:
- Sequential key-delivery block for the RLL-locked benchmark netlists. It is the writer side of the 16-bit key interface that those netlists read on keyIn_0_0..keyIn_0_15.
- It receives the key as a serial bit stream from secure storage and checks the stream's parity.
- On success it drives the key bus with a registered key and asserts key_valid.
- On repeated failures it enters a permanent lockout until reset.

Parameters:
- KEY_WIDTH, 16, number of key bits; key_out[i] drives keyIn_0_i.
- MAX_FAILS, 3, consecutive failed loads that force LOCKOUT.
- TIMEOUT, 64, idle cycles allowed between accepted bits while loading.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a key load. Honoured only in IDLE or ACTIVE.
- ser_valid  input  1  serial source has a bit on ser_data.
- ser_data  input  1  serial key/parity bit.
- ser_ready  output  1  loader accepts a bit this cycle. High only in LOAD.
- key_out  output  KEY_WIDTH  key bus to the locked netlist.
- key_valid  output  1  key_out holds a parity-checked key.
- busy  output  1  state is LOAD or CHECK.
- error  output  1  one-cycle pulse on each failed load (parity or timeout).
- lockout  output  1  high while in LOCKOUT.
- fail_count  output  $clog2(MAX_FAILS+1)  number of consecutive failed loads.

Behaviour:
- Reset values:
  - State is IDLE.
  - key_out=0, key_valid=0, ser_ready=0, busy=0, error=0, lockout=0, fail_count=0.
  - Shift register, bit counter and timeout counter are all 0.
- Frame format:
  - KEY_WIDTH data bits, LSB first (the first accepted bit becomes key bit 0).
  - One even-parity bit follows: the XOR of all KEY_WIDTH+1 bits must be 0.
- A bit is accepted on a rising edge where ser_valid and ser_ready are both 1. ser_data is ignored otherwise.
- States:
  - IDLE: start=1 -> LOAD. Shift register, bit counter and timeout counter are cleared on that edge.
  - LOAD:
    - ser_ready=1, busy=1.
    - Each accepted bit increments the bit counter and clears the timeout counter.
    - Each cycle without an accepted bit increments the timeout counter.
    - Accepting bit number KEY_WIDTH+1 (the parity bit) -> CHECK.
    - Timeout counter reaching TIMEOUT -> failure path.
  - CHECK: exactly one cycle; ser_ready=0, busy=1.
    - Parity OK: on the leaving edge, key_out <= assembled key, key_valid <= 1, fail_count <= 0, go to ACTIVE.
    - Parity bad: failure path.
  - ACTIVE:
    - key_out and key_valid are held stable.
    - start=1 -> LOAD. key_valid <= 0 and key_out <= 0 on that same edge, so a partial key never reaches the netlist.
  - Failure path (from LOAD timeout or CHECK parity error):
    - error pulses high for one cycle, and fail_count increments.
    - If the incremented fail_count equals MAX_FAILS -> LOCKOUT. Otherwise -> IDLE.
  - LOCKOUT: lockout=1, key_out=0, key_valid=0, ser_ready=0. start is ignored. Only rst exits.
- Latency: key_valid is high starting in the second cycle after the edge that accepts the parity bit (LOAD -> CHECK -> ACTIVE).
- start is ignored in LOAD, CHECK and LOCKOUT. A start held high in ACTIVE causes exactly one reload per entry into ACTIVE.
- rst mid-load or in any state: everything returns to reset values on the next edge. fail_count is cleared, so rst also clears LOCKOUT.
- key_out changes only on three events:
  - a successful CHECK (loads the new key);
  - start from ACTIVE (clears to 0);
  - rst (clears to 0).
- All outputs are registered. There is no combinational path from ser_data to key_out.

Test Plan:
- Good load: reset; pulse start; send 0xA5C3 LSB first with parity 0, ser_valid held high.
  - key_out=0xA5C3 and key_valid=1 from the second cycle after the parity bit is accepted.
  - busy was high for 18 cycles; fail_count=0.
- Parity error: send 0xA5C3 with parity 1.
  - error pulses for one cycle; fail_count=1; state returns to IDLE.
  - key_valid=0 and key_out=0.
- Lockout: three consecutive bad-parity frames.
  - lockout=1 after the third; fail_count=3.
  - A later start is ignored (ser_ready stays 0).
  - After rst, the state is IDLE and a good frame loads normally.
- Timeout: start, send 5 bits, then hold ser_valid=0 for 64 cycles.
  - error pulses and fail_count=1.
  - The next good frame loads with no stale bits, and fail_count returns to 0.
- Reload and backpressure: in ACTIVE with 0xA5C3, pulse start; send 0x1234 (popcount 5, parity 1) with ser_valid toggling every other cycle.
  - key_valid drops and key_out goes to 0 on the start edge.
  - Only the handshaked bits are captured; final key_out=0x1234.
- Reset mid-load: assert rst after 9 accepted bits.
  - All outputs are at reset values on the next edge.
  - A subsequent full good frame yields the correct key.

Source files
------------

// File: rtl/rll_key_loader.sv
// Serial key loader for RLL-locked netlists: assembles an even-parity framed key,
// drives it on the key bus once checked, and locks out after repeated failed loads.
module rll_key_loader #(
  parameter int unsigned KEY_WIDTH = 16,
  parameter int unsigned MAX_FAILS = 3,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             ser_valid,
  input  logic                             ser_data,
  output logic                             ser_ready,
  output logic [KEY_WIDTH-1:0]             key_out,
  output logic                             key_valid,
  output logic                             busy,
  output logic                             error,
  output logic                             lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int unsigned FcW = $clog2(MAX_FAILS + 1);
  localparam int unsigned BcW = $clog2(KEY_WIDTH + 2);
  localparam int unsigned TcW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StActive, StLockout} state_e;

  state_e             state;
  logic [KEY_WIDTH:0] shreg;
  logic [BcW-1:0]     bit_cnt;
  logic [TcW-1:0]     tmo_cnt;

  logic           accept;
  logic           fail_now;
  logic [FcW-1:0] fc_inc;

  always_comb begin
    accept   = (state == StLoad) && ser_valid && ser_ready;
    fc_inc   = fail_count + FcW'(1);
    fail_now = ((state == StLoad) && !accept && (tmo_cnt == TcW'(TIMEOUT - 1))) ||
               ((state == StCheck) && (^shreg));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      shreg      <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      ser_ready  <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
      lockout    <= 1'b0;
      fail_count <= '0;
    end else begin
      error <= 1'b0;
      unique case (state)
        StIdle, StActive: begin
          if (start) begin
            state     <= StLoad;
            shreg     <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            ser_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StLoad: begin
          if (accept) begin
            // Shift in from the top so the first bit ends up at index 0.
            shreg   <= {ser_data, shreg[KEY_WIDTH:1]};
            bit_cnt <= bit_cnt + BcW'(1);
            tmo_cnt <= '0;
            if (bit_cnt == BcW'(KEY_WIDTH)) begin
              state     <= StCheck;
              ser_ready <= 1'b0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TcW'(1);
          end
        end
        StCheck: begin
          if (!(^shreg)) begin
            state      <= StActive;
            key_out    <= shreg[KEY_WIDTH-1:0];
            key_valid  <= 1'b1;
            fail_count <= '0;
            busy       <= 1'b0;
          end
        end
        StLockout: begin
        end
        default: state <= StIdle;
      endcase

      // Shared failure path for load timeout and bad parity.
      if (fail_now) begin
        error      <= 1'b1;
        fail_count <= fc_inc;
        ser_ready  <= 1'b0;
        busy       <= 1'b0;
        key_out    <= '0;
        key_valid  <= 1'b0;
        if (fc_inc == FcW'(MAX_FAILS)) begin
          state   <= StLockout;
          lockout <= 1'b1;
        end else begin
          state <= StIdle;
        end
      end
    end
  end

endmodule
